// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared constants, register-select encoding and byte-lane
//                merge helper for the 64-bit APB timer register file.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

  // Largest legal prescaler exponent (tick every 2^DIV_MAX cycles)
  localparam int DIV_MAX = 8;

  // Register word offsets
  localparam int TCR_A   = 'h000;
  localparam int TDR0_A  = 'h004;
  localparam int TDR1_A  = 'h008;
  localparam int TCMP0_A = 'h00C;
  localparam int TCMP1_A = 'h010;
  localparam int TIER_A  = 'h014;
  localparam int TISR_A  = 'h018;
  localparam int THCSR_A = 'h01C;

  // Reset values
  localparam logic [31:0] TCR_RST  = 32'h0000_0100;
  localparam logic [31:0] TDR_RST  = 32'h0000_0000;
  localparam logic [31:0] TCMP_RST = 32'hFFFF_FFFF;

  // Implemented TCR bits: [11:8] div_val, [1] div_en, [0] timer_en
  localparam logic [31:0] TCR_MASK = 32'h0000_0F03;

  typedef enum logic [3:0] {
    SEL_TCR,
    SEL_TDR0,
    SEL_TDR1,
    SEL_TCMP0,
    SEL_TCMP1,
    SEL_TIER,
    SEL_TISR,
    SEL_THCSR,
    SEL_NONE
  } reg_sel_e;

  // Replace only the byte lanes whose strobe is set
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int n = 0; n < 4; n++) begin
      if (strb[n]) res[8*n +: 8] = new_v[8*n +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/timer_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : timer_cnt
//  Description : Prescaler and free-running counter of the APB timer.
//                A tick is produced every cycle (div_en=0) or every
//                2^div_val cycles (div_en=1); each tick adds one to the
//                counter. Word loads from the register file override the
//                addressed word and suppress any carry into the other word.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                timer_en_i     - run enable
//                div_en_i       - prescaler enable
//                div_val_i      - prescaler exponent (saturated at DIV_MAX)
//                halt_i         - freeze prescaler and counter
//                ps_clr_i       - restart prescaler (TCR written)
//                ld_lo_i/ld_hi_i- load low / high counter word
//                ld_data_i      - load data (already byte-merged)
//                cnt_o          - counter value
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_cnt #(
  parameter int CNT_W   = 64,
  parameter int DIV_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             timer_en_i,
  input  logic             div_en_i,
  input  logic [3:0]       div_val_i,
  input  logic             halt_i,
  input  logic             ps_clr_i,
  input  logic             ld_lo_i,
  input  logic             ld_hi_i,
  input  logic [31:0]      ld_data_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int          HI_W   = CNT_W - 32;
  localparam int          PS_W   = DIV_MAX;
  localparam logic [3:0]  DV_SAT = 4'(DIV_MAX);

  logic [PS_W-1:0]  ps_q, ps_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q;

  logic [3:0]       w_dv;
  logic [PS_W-1:0]  w_term;
  logic             w_tick;
  logic             w_clr;
  logic [CNT_W-1:0] w_base;

  always_comb begin
    w_dv   = (div_val_i > DV_SAT) ? DV_SAT : div_val_i;
    // Terminal count 2^dv - 1 as a right-shifted all-ones word
    w_term = {PS_W{1'b1}} >> (DV_SAT - w_dv);
    w_tick = timer_en_i & ~halt_i & (~div_en_i | (ps_q == w_term));
    // Falling edge of the run enable wipes the count
    w_clr  = en_q & ~timer_en_i;

    if (!timer_en_i || ps_clr_i) begin
      ps_d = '0;
    end else if (halt_i) begin
      ps_d = ps_q;
    end else if (div_en_i && !w_tick) begin
      ps_d = ps_q + PS_W'(1);
    end else begin
      ps_d = '0;
    end

    w_base = w_clr ? '0 : cnt_q;
    cnt_d  = w_tick ? (cnt_q + CNT_W'(1)) : w_base;
    // A load keeps the untouched word exactly as it was (no carry this cycle)
    if (ld_lo_i) begin
      cnt_d = {w_base[CNT_W-1:32], ld_data_i};
    end else if (ld_hi_i) begin
      cnt_d = {ld_data_i[HI_W-1:0], w_base[31:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q  <= '0;
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      ps_q  <= ps_d;
      cnt_q <= cnt_d;
      en_q  <= timer_en_i;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/timer_core.sv
`default_nettype none
// ============================================================================
//  Module      : timer_core
//  Description : Register file and counting engine of the 64-bit APB timer.
//                Decodes qualified APB accesses, holds TCR/TCMP/TIER/TISR,
//                drives the read mux and the registered interrupt output,
//                and instantiates timer_cnt for the prescaler and counter.
//  Build macro : TIMER_HALT_EN - adds dbg_mode and THCSR (0x01C) halt control
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                dbg_mode        - debug halt source (TIMER_HALT_EN only)
//                wr_en, rd_en    - qualified access strobes
//                pslverr         - setup-stage error, blocks the write
//                addr/wdata/pstrb- raw APB address, data, byte strobes
//                prdata          - combinational read data
//                timer_en/div_en/div_val - TCR fields for the setup stage
//                tim_int         - registered interrupt
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_core #(
  parameter int CNT_W   = 64,
  parameter int DIV_MAX = timer_pkg::DIV_MAX,
  parameter int ADDR_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
`ifdef TIMER_HALT_EN
  input  logic              dbg_mode,
`endif
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              pslverr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        pstrb,
  output logic [31:0]       prdata,
  output logic              timer_en,
  output logic              div_en,
  output logic [3:0]        div_val,
  output logic              tim_int
);

  import timer_pkg::*;

  localparam int HI_W = CNT_W - 32;

  logic [31:0]      tcr_q, tcr_d;
  logic [31:0]      tcmp0_q, tcmp0_d;
  logic [31:0]      tcmp1_q, tcmp1_d;
  logic             tier_q, tier_d;
  logic             int_st_q, int_st_d;
  logic             tim_int_q;

  reg_sel_e         w_sel;
  logic             w_wr;
  logic [CNT_W-1:0] w_cnt;
  logic [31:0]      w_cnt_lo, w_cnt_hi;
  logic [31:0]      w_ld_data;
  logic             w_ld_lo, w_ld_hi;
  logic             w_match, w_w1c;
  logic             w_halt;

  // ---------------------------------------------------------------- decode
  always_comb begin
    w_sel = SEL_NONE;
    if      (addr == ADDR_W'(TCR_A))   w_sel = SEL_TCR;
    else if (addr == ADDR_W'(TDR0_A))  w_sel = SEL_TDR0;
    else if (addr == ADDR_W'(TDR1_A))  w_sel = SEL_TDR1;
    else if (addr == ADDR_W'(TCMP0_A)) w_sel = SEL_TCMP0;
    else if (addr == ADDR_W'(TCMP1_A)) w_sel = SEL_TCMP1;
    else if (addr == ADDR_W'(TIER_A))  w_sel = SEL_TIER;
    else if (addr == ADDR_W'(TISR_A))  w_sel = SEL_TISR;
`ifdef TIMER_HALT_EN
    else if (addr == ADDR_W'(THCSR_A)) w_sel = SEL_THCSR;
`endif
  end

  assign w_wr = wr_en & ~pslverr;

  // ----------------------------------------------------------- halt control
`ifdef TIMER_HALT_EN
  logic halt_req_q, halt_req_d;
  logic w_halt_ack;

  assign w_halt_ack = halt_req_q & dbg_mode;
  assign w_halt     = w_halt_ack;

  always_comb begin
    halt_req_d = halt_req_q;
    if (w_wr && (w_sel == SEL_THCSR) && pstrb[0]) halt_req_d = wdata[0];
  end

  always_ff @(posedge clk) begin
    if (rst) halt_req_q <= 1'b0;
    else     halt_req_q <= halt_req_d;
  end
`else
  assign w_halt = 1'b0;
`endif

  // ------------------------------------------------------ counter interface
  assign w_cnt_lo  = w_cnt[31:0];
  assign w_cnt_hi  = 32'(w_cnt[CNT_W-1:32]);
  assign w_ld_lo   = w_wr & (w_sel == SEL_TDR0);
  assign w_ld_hi   = w_wr & (w_sel == SEL_TDR1);
  // Partial-strobe TDR writes keep the current counter bytes in unused lanes
  assign w_ld_data = byte_merge((w_sel == SEL_TDR1) ? w_cnt_hi : w_cnt_lo,
                                wdata, pstrb);

  timer_cnt #(
    .CNT_W   (CNT_W),
    .DIV_MAX (DIV_MAX)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .timer_en_i (tcr_q[0]),
    .div_en_i   (tcr_q[1]),
    .div_val_i  (tcr_q[11:8]),
    .halt_i     (w_halt),
    .ps_clr_i   (w_wr & (w_sel == SEL_TCR)),
    .ld_lo_i    (w_ld_lo),
    .ld_hi_i    (w_ld_hi),
    .ld_data_i  (w_ld_data),
    .cnt_o      (w_cnt)
  );

  // --------------------------------------------------- register next-state
  always_comb begin
    tcr_d   = tcr_q;
    tcmp0_d = tcmp0_q;
    tcmp1_d = tcmp1_q;
    tier_d  = tier_q;
    if (w_wr) begin
      case (w_sel)
        SEL_TCR:   tcr_d   = byte_merge(tcr_q, wdata, pstrb) & TCR_MASK;
        SEL_TCMP0: tcmp0_d = byte_merge(tcmp0_q, wdata, pstrb);
        SEL_TCMP1: tcmp1_d = byte_merge(tcmp1_q, wdata, pstrb);
        SEL_TIER:  if (pstrb[0]) tier_d = wdata[0];
        default:   ;
      endcase
    end

    // Compare is evaluated whether or not the timer runs; set beats W1C
    w_match  = (w_cnt == {tcmp1_q[HI_W-1:0], tcmp0_q});
    w_w1c    = w_wr & (w_sel == SEL_TISR) & pstrb[0] & wdata[0];
    int_st_d = w_match | (int_st_q & ~w_w1c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcr_q     <= TCR_RST;
      tcmp0_q   <= TCMP_RST;
      tcmp1_q   <= TCMP_RST;
      tier_q    <= 1'b0;
      int_st_q  <= 1'b0;
      tim_int_q <= 1'b0;
    end else begin
      tcr_q     <= tcr_d;
      tcmp0_q   <= tcmp0_d;
      tcmp1_q   <= tcmp1_d;
      tier_q    <= tier_d;
      int_st_q  <= int_st_d;
      tim_int_q <= int_st_q & tier_q;
    end
  end

  // --------------------------------------------------------------- read mux
  always_comb begin
    prdata = '0;
    if (rd_en && !rst) begin
      case (w_sel)
        SEL_TCR:   prdata = tcr_q;
        SEL_TDR0:  prdata = w_cnt_lo;
        SEL_TDR1:  prdata = w_cnt_hi;
        SEL_TCMP0: prdata = tcmp0_q;
        SEL_TCMP1: prdata = tcmp1_q;
        SEL_TIER:  prdata = {31'b0, tier_q};
        SEL_TISR:  prdata = {31'b0, int_st_q};
`ifdef TIMER_HALT_EN
        SEL_THCSR: prdata = {30'b0, w_halt_ack, halt_req_q};
`endif
        default:   prdata = '0;
      endcase
    end
  end

  assign timer_en = tcr_q[0];
  assign div_en   = tcr_q[1];
  assign div_val  = tcr_q[11:8];
  assign tim_int  = tim_int_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_core
//  Description : Self-checking bench for timer_core with a cycle-level
//                behavioural model of the register map, prescaler, counter
//                and interrupt. Honours TIMER_HALT_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0, pslverr = 1'b0;
  logic [11:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  pstrb = '0;
  logic [31:0] prdata;
  logic        timer_en, div_en, tim_int;
  logic [3:0]  div_val;
`ifdef TIMER_HALT_EN
  logic        dbg_mode = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  timer_core dut (
    .clk      (clk),
    .rst      (rst),
`ifdef TIMER_HALT_EN
    .dbg_mode (dbg_mode),
`endif
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .pslverr  (pslverr),
    .addr     (addr),
    .wdata    (wdata),
    .pstrb    (pstrb),
    .prdata   (prdata),
    .timer_en (timer_en),
    .div_en   (div_en),
    .div_val  (div_val),
    .tim_int  (tim_int)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------------ model state
  logic [31:0] m_tcr, m_cmp0, m_cmp1;
  logic [63:0] m_cnt;
  logic        m_ier, m_ist, m_tint, m_prev_en, m_hreq;
  int          m_pre;

  function automatic logic [31:0] lane_mix(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~mask) | (n & mask);
  endfunction

  task automatic model_reset();
    m_tcr = 32'h100; m_cmp0 = '1; m_cmp1 = '1; m_cnt = '0;
    m_ier = 0; m_ist = 0; m_tint = 0; m_prev_en = 0; m_hreq = 0; m_pre = 0;
  endtask

  function automatic logic halt_now();
`ifdef TIMER_HALT_EN
    return m_hreq & dbg_mode;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h000: return m_tcr;
      12'h004: return m_cnt[31:0];
      12'h008: return m_cnt[63:32];
      12'h00C: return m_cmp0;
      12'h010: return m_cmp1;
      12'h014: return {31'b0, m_ier};
      12'h018: return {31'b0, m_ist};
`ifdef TIMER_HALT_EN
      12'h01C: return {30'b0, halt_now(), m_hreq};
`endif
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs applied in this cycle
  task automatic model_edge(input logic wr, input logic err, input logic [11:0] a,
                            input logic [31:0] d, input logic [3:0] s);
    logic w, en, den, hlt, tick, clr, match;
    int dv, period, npre;
    logic [63:0] ncnt;
    if (rst) begin model_reset(); return; end
    w   = wr && !err;
    en  = m_tcr[0];
    den = m_tcr[1];
    hlt = halt_now();
    dv  = int'(m_tcr[11:8]);
    if (dv > 8) dv = 8;
    period = den ? (1 << dv) : 1;
    tick   = en && !hlt && (m_pre == period - 1);
    if (!en || (w && a == 12'h000)) npre = 0;
    else if (hlt)                   npre = m_pre;
    else if (tick)                  npre = 0;
    else                            npre = m_pre + 1;
    clr  = m_prev_en && !en;
    ncnt = clr ? 64'd0 : (tick ? m_cnt + 64'd1 : m_cnt);
    if (w && (a == 12'h004 || a == 12'h008)) begin
      ncnt = clr ? 64'd0 : m_cnt;
      if (a == 12'h004) ncnt[31:0]  = lane_mix(m_cnt[31:0], d, s);
      else              ncnt[63:32] = lane_mix(m_cnt[63:32], d, s);
    end
    match  = (m_cnt == {m_cmp1, m_cmp0});
    m_tint = m_ist & m_ier;
    m_ist  = match | (m_ist & !(w && a == 12'h018 && s[0] && d[0]));
    if (w) begin
      case (a)
        12'h000: m_tcr  = lane_mix(m_tcr, d, s) & 32'h0F03;
        12'h00C: m_cmp0 = lane_mix(m_cmp0, d, s);
        12'h010: m_cmp1 = lane_mix(m_cmp1, d, s);
        12'h014: if (s[0]) m_ier = d[0];
`ifdef TIMER_HALT_EN
        12'h01C: if (s[0]) m_hreq = d[0];
`endif
        default: ;
      endcase
    end
    m_pre = npre; m_cnt = ncnt; m_prev_en = en;
  endtask

  // One bus cycle: drive, sample mid-cycle, advance model at the clock edge
  task automatic bus(input logic wr, input logic rd, input logic err, input logic [11:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] o_rd, output logic o_int,
                     output logic [31:0] e_rd, output logic e_int);
    wr_en = wr; rd_en = rd; pslverr = err; addr = a; wdata = d; pstrb = s;
    #3;
    o_rd  = prdata;
    o_int = tim_int;
    e_rd  = (rd && !rst) ? m_read(a) : 32'h0;
    e_int = m_tint;
    @(posedge clk);
    model_edge(wr, err, a, d, s);
    #1;
    wr_en = 0; rd_en = 0; pslverr = 0; addr = '0; wdata = '0; pstrb = '0;
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    logic [31:0] o, e; logic oi, ei;
    logic [31:0] exp_tab [8];
    exp_tab = '{32'h100, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
    rst = 1;
    @(posedge clk); model_reset();
    @(posedge clk); model_reset();
    #1 rst = 0;
    for (int i = 0; i < 8; i++) begin
      bus(0, 1, 0, 12'(i * 4), 0, 0, o, oi, e, ei);
      n_cmp++;
      if (o !== exp_tab[i]) begin
        $display("FAIL reset_read[%0h]: got %h expected %h", i * 4, o, exp_tab[i]); n_bad++;
      end
    end
    n_cmp++;
    if (oi !== 1'b0) begin $display("FAIL reset_tim_int: got %b expected 0", oi); n_bad++; end
    bus(0, 0, 0, 12'h000, 0, 0, o, oi, e, ei);
    n_cmp++;
    if (o !== 32'h0) begin $display("FAIL idle_prdata: got %h expected 0", o); n_bad++; end
  endtask

  task automatic test_strobes_err();
    logic [31:0] o, e; logic oi, ei;
    bus(1, 0, 0, 12'h00C, 32'hAABB_CCDD, 4'b0101, o, oi, e, ei);
    bus(0, 1, 0, 12'h00C, 0, 0, o, oi, e, ei);
    n_cmp++;
    if (o !== 32'hFFBB_FFDD) begin $display("FAIL strobe_tcmp0: got %h expected ffbbffdd", o); n_bad++; end
    bus(1, 0, 1, 12'h000, 32'h0000_0F03, 4'hF, o, oi, e, ei);
    bus(0, 1, 0, 12'h000, 0, 0, o, oi, e, ei);
    n_cmp++;
    if (o !== 32'h100) begin $display("FAIL pslverr_tcr: got %h expected 00000100", o); n_bad++; end
    n_cmp++;
    if (timer_en !== 1'b0) begin $display("FAIL pslverr_timer_en: got %b expected 0", timer_en); n_bad++; end
  endtask

  task automatic test_div4();
    logic [31:0] o, e, prev; logic oi, ei;
    int last_chg;
    bus(1, 0, 0, 12'h000, 32'h0000_0203, 4'hF, o, oi, e, ei);
    n_cmp++;
    if ({div_val, div_en, timer_en} !== 6'b0010_11) begin
      $display("FAIL div4_tcr_fields: got %b expected 001011", {div_val, div_en, timer_en}); n_bad++;
    end
    prev = 0; last_chg = -1;
    for (int i = 0; i < 41; i++) begin
      bus(0, 1, 0, 12'h004, 0, 0, o, oi, e, ei);
      n_cmp++;
      if (o !== e) begin $display("FAIL div4_tdr0[%0d]: got %h expected %h", i, o, e); n_bad++; end
      if (o !== prev) begin
        if (last_chg >= 0) begin
          n_cmp++;
          if (i - last_chg != 4) begin
            $display("FAIL div4_spacing: got %0d expected 4", i - last_chg); n_bad++;
          end
        end
        last_chg = i;
      end
      prev = o;
    end
    n_cmp++;
    if (o < 9 || o > 11) begin $display("FAIL div4_final: got %0d expected 10+-1", o); n_bad++; end
  endtask

  task automatic test_wrap_compare();
    logic [31:0] o, e; logic oi, ei;
    bit found;
    bus(1, 0, 0, 12'h000, 32'h0, 4'hF, o, oi, e, ei);
    bus(0, 0, 0, 12'h000, 0, 0, o, oi, e, ei);
    bus(1, 0, 0, 12'h008, 32'h0, 4'hF, o, oi, e, ei);
    bus(1, 0, 0, 12'h004, 32'hFFFF_FFFE, 4'hF, o, oi, e, ei);
    bus(1, 0, 0, 12'h010, 32'h1, 4'hF, o, oi, e, ei);
    bus(1, 0, 0, 12'h00C, 32'h0, 4'hF, o, oi, e, ei);
    bus(1, 0, 0, 12'h014, 32'h1, 4'hF, o, oi, e, ei);
    bus(1, 0, 0, 12'h000, 32'h1, 4'hF, o, oi, e, ei);
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      bus(0, 1, 0, 12'h018, 0, 0, o, oi, e, ei);
      n_cmp++;
      if (o !== e || oi !== ei) begin
        $display("FAIL wrap_tisr[%0d]: got %h/%b expected %h/%b", i, o, oi, e, ei); n_bad++;
      end
      if (o === 32'h1) begin
        found = 1;
        n_cmp++;
        if (oi !== 1'b0) begin $display("FAIL wrap_int_latency: got %b expected 0", oi); n_bad++; end
      end
    end
    n_cmp++;
    if (!found) begin $display("FAIL wrap_int_st: got 0 expected 1 within 8 cycles"); n_bad++; end
    bus(0, 1, 0, 12'h008, 0, 0, o, oi, e, ei);
    n_cmp++;
    if (o !== 32'h1 || oi !== 1'b1) begin
      $display("FAIL wrap_tdr1_int: got %h/%b expected 00000001/1", o, oi); n_bad++;
    end
    bus(1, 0, 0, 12'h018, 32'h1, 4'h1, o, oi, e, ei);
    bus(0, 1, 0, 12'h018, 0, 0, o, oi, e, ei);
    n_cmp++;
    if (o !== 32'h0 || o !== e) begin $display("FAIL w1c_tisr: got %h expected 0", o); n_bad++; end
    bus(0, 0, 0, 12'h000, 0, 0, o, oi, e, ei);
    n_cmp++;
    if (oi !== 1'b0 || oi !== ei) begin $display("FAIL w1c_tim_int: got %b expected 0", oi); n_bad++; end
    // Clear while the compare still matches: the set must win
    bus(1, 0, 0, 12'h000, 32'h0, 4'hF, o, oi, e, ei);
    bus(0, 0, 0, 12'h000, 0, 0, o, oi, e, ei);
    bus(1, 0, 0, 12'h008, 32'h1, 4'hF, o, oi, e, ei);
    bus(1, 0, 0, 12'h004, 32'h0, 4'hF, o, oi, e, ei);
    bus(0, 0, 0, 12'h000, 0, 0, o, oi, e, ei);
    bus(1, 0, 0, 12'h018, 32'h1, 4'hF, o, oi, e, ei);
    bus(0, 1, 0, 12'h018, 0, 0, o, oi, e, ei);
    n_cmp++;
    if (o !== 32'h1 || o !== e) begin $display("FAIL set_beats_w1c: got %h expected 00000001", o); n_bad++; end
  endtask

  task automatic test_disable();
    logic [31:0] o, e; logic oi, ei;
    bit found;
    logic [31:0] rd_hist [10];
    bus(1, 0, 0, 12'h008, 32'h0, 4'hF, o, oi, e, ei);
    bus(1, 0, 0, 12'h004, 32'h40, 4'hF, o, oi, e, ei);
    bus(1, 0, 0, 12'h000, 32'h1, 4'hF, o, oi, e, ei);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      bus(0, 1, 0, 12'h004, 0, 0, o, oi, e, ei);
      n_cmp++;
      if (o !== e) begin $display("FAIL dis_run[%0d]: got %h expected %h", i, o, e); n_bad++; end
      if (o === 32'h50) found = 1;
    end
    n_cmp++;
    if (!found) begin $display("FAIL dis_reach50: got %h expected 00000050", o); n_bad++; end
    bus(1, 0, 0, 12'h000, 32'h0, 4'hF, o, oi, e, ei);
    bus(0, 0, 0, 12'h000, 0, 0, o, oi, e, ei);
    bus(0, 1, 0, 12'h004, 0, 0, o, oi, e, ei);
    n_cmp++;
    if (o !== 32'h0) begin $display("FAIL dis_clear: got %h expected 0", o); n_bad++; end
    bus(1, 0, 0, 12'h000, 32'h203, 4'hF, o, oi, e, ei);
    for (int i = 0; i < 10; i++) begin
      bus(0, 1, 0, 12'h004, 0, 0, o, oi, e, ei);
      rd_hist[i] = o;
      n_cmp++;
      if (o !== e) begin $display("FAIL reen_run[%0d]: got %h expected %h", i, o, e); n_bad++; end
    end
    n_cmp++;
    if (rd_hist[3] !== 32'h0 || rd_hist[4] !== 32'h1) begin
      $display("FAIL reen_prescale: got %h,%h expected 0,1", rd_hist[3], rd_hist[4]); n_bad++;
    end
    bus(1, 0, 0, 12'h000, 32'h0, 4'hF, o, oi, e, ei);
  endtask

`ifdef TIMER_HALT_EN
  task automatic test_halt();
    logic [31:0] o, e, a0; logic oi, ei;
    bus(1, 0, 0, 12'h000, 32'h1, 4'hF, o, oi, e, ei);
    dbg_mode = 1;
    bus(1, 0, 0, 12'h01C, 32'h1, 4'hF, o, oi, e, ei);
    bus(0, 1, 0, 12'h01C, 0, 0, o, oi, e, ei);
    n_cmp++;
    if (o !== 32'h3) begin $display("FAIL halt_thcsr: got %h expected 00000003", o); n_bad++; end
    bus(0, 1, 0, 12'h004, 0, 0, a0, oi, e, ei);
    for (int i = 0; i < 3; i++) begin
      bus(0, 1, 0, 12'h004, 0, 0, o, oi, e, ei);
      n_cmp++;
      if (o !== a0 || o !== e) begin $display("FAIL halt_frozen[%0d]: got %h expected %h", i, o, a0); n_bad++; end
    end
    dbg_mode = 0;
    bus(0, 0, 0, 12'h000, 0, 0, o, oi, e, ei);
    bus(0, 1, 0, 12'h004, 0, 0, o, oi, e, ei);
    n_cmp++;
    if (o === a0 || o !== e) begin $display("FAIL halt_resume: got %h expected %h", o, e); n_bad++; end
    bus(1, 0, 0, 12'h01C, 32'h0, 4'hF, o, oi, e, ei);
    bus(1, 0, 0, 12'h000, 32'h0, 4'hF, o, oi, e, ei);
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] o, e; logic oi, ei;
    bus(1, 0, 0, 12'h000, 32'h1, 4'hF, o, oi, e, ei);
    repeat (3) bus(0, 0, 0, 12'h000, 0, 0, o, oi, e, ei);
    rst = 1;
    bus(1, 0, 0, 12'h000, 32'h0000_0F03, 4'hF, o, oi, e, ei);
    rst = 0;
    bus(0, 1, 0, 12'h000, 0, 0, o, oi, e, ei);
    n_cmp++;
    if (o !== 32'h100) begin $display("FAIL rstmid_tcr: got %h expected 00000100", o); n_bad++; end
    bus(0, 1, 0, 12'h004, 0, 0, o, oi, e, ei);
    n_cmp++;
    if (o !== 32'h0) begin $display("FAIL rstmid_tdr0: got %h expected 0", o); n_bad++; end
  endtask

  task automatic test_back_to_back();
    logic [31:0] o, e, d; logic oi, ei;
    logic [11:0] a;
    logic [3:0]  s;
    int op;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 149) == 0);
`ifdef TIMER_HALT_EN
      dbg_mode = 1'($urandom_range(0, 1));
`endif
      op = $urandom_range(0, 2);
      a  = 12'($urandom_range(0, 9) * 4);
      d  = $urandom;
      if (a == 12'h000) begin
        d = d & 32'hFFFF_F3FF;
        d[0] = ($urandom_range(0, 3) != 0);
      end
      if ((a == 12'h00C || a == 12'h004) && $urandom_range(0, 1) == 1) d = $urandom_range(0, 40);
      if (a == 12'h010 || a == 12'h008) d = ($urandom_range(0, 1) == 1) ? 32'h0 : d;
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      bus(op == 1, op == 2, ($urandom_range(0, 7) == 0), a, d, s, o, oi, e, ei);
      rst = 0;
      n_cmp++;
      if (o !== e || oi !== ei) begin
        $display("FAIL rand[%0d] a=%h: got %h/%b expected %h/%b", i, a, o, oi, e, ei); n_bad++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_strobes_err();
    test_div4();
    test_wrap_compare();
    test_disable();
`ifdef TIMER_HALT_EN
    test_halt();
`endif
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
